// File: rtl/bus_mem_ctrl.sv
// CPU bus responder: loadable ROM at address 0, RAM window at RAM_BASE, open-bus
// reads elsewhere, with per-direction wait states and error pulses on illegal accesses.
module bus_mem_ctrl #(
    parameter int unsigned            ADDR_WIDTH = 16,
    parameter int unsigned            DATA_WIDTH = 8,
    parameter int unsigned            ROM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0]  RAM_BASE   = 16'hC000,
    parameter int unsigned            RAM_DEPTH  = 256,
    parameter int unsigned            READ_WAIT  = 1,
    parameter int unsigned            WRITE_WAIT = 1,
    parameter logic [DATA_WIDTH-1:0]  OPEN_BUS   = 8'hFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         cpu_address,
    input  logic [DATA_WIDTH-1:0]         cpu_wdata,
    input  logic                          cpu_read,
    input  logic                          cpu_write,
    output logic [DATA_WIDTH-1:0]         cpu_rdata,
    output logic                          cpu_done,
    output logic                          cpu_wait,
    input  logic                          load_en,
    input  logic [$clog2(ROM_DEPTH)-1:0]  load_address,
    input  logic [DATA_WIDTH-1:0]         load_data,
    output logic                          err_unmapped,
    output logic                          err_rom_write,
    output logic                          busy
);

    localparam int unsigned ROM_AW = $clog2(ROM_DEPTH);
    localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
    localparam int unsigned CMP_W  = ADDR_WIDTH + 1;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(READ_WAIT);
    localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WRITE_WAIT);
    localparam logic [CMP_W-1:0] ROM_END = CMP_W'(ROM_DEPTH);
    localparam logic [CMP_W-1:0] RAM_LO  = CMP_W'(RAM_BASE);
    localparam logic [CMP_W-1:0] RAM_HI  = CMP_W'(RAM_BASE) + CMP_W'(RAM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    is_read_q, is_read_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    done_q, done_d;
    logic                    err_unm_q, err_unm_d;
    logic                    err_rom_q, err_rom_d;
    logic                    busy_q, busy_d;
    logic                    ram_we_c;

    logic [DATA_WIDTH-1:0]   rom_mem [ROM_DEPTH];
    logic [DATA_WIDTH-1:0]   ram_mem [RAM_DEPTH];

    logic                    hit_rom_c;
    logic                    hit_ram_c;
    logic [ROM_AW-1:0]       rom_idx_c;
    logic [RAM_AW-1:0]       ram_idx_c;
    logic [DATA_WIDTH-1:0]   rom_word_c;
    logic [DATA_WIDTH-1:0]   ram_word_c;

    // Decode is done on the latched address, widened by one bit so the RAM top bound cannot wrap.
    assign hit_rom_c  = CMP_W'(addr_q) < ROM_END;
    assign hit_ram_c  = (CMP_W'(addr_q) >= RAM_LO) && (CMP_W'(addr_q) < RAM_HI);
    assign rom_idx_c  = addr_q[ROM_AW-1:0];
    assign ram_idx_c  = RAM_AW'(addr_q - RAM_BASE);
    assign rom_word_c = rom_mem[rom_idx_c];
    assign ram_word_c = ram_mem[ram_idx_c];

    assign cpu_wait      = (cpu_read | cpu_write) & ~done_q;
    assign cpu_rdata     = rdata_q;
    assign cpu_done      = done_q;
    assign err_unmapped  = err_unm_q;
    assign err_rom_write = err_rom_q;
    assign busy          = busy_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        rdata_d   = rdata_q;
        done_d    = 1'b0;
        err_unm_d = 1'b0;
        err_rom_d = 1'b0;
        ram_we_c  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_read || cpu_write) begin
                    addr_d    = cpu_address;
                    wdata_d   = cpu_wdata;
                    is_read_d = cpu_read;
                    cnt_d     = cpu_read ? RD_CNT : WR_CNT;
                    state_d   = (cnt_d != '0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                if (is_read_q) begin
                    if (hit_rom_c) begin
                        rdata_d = rom_word_c;
                    end else if (hit_ram_c) begin
                        rdata_d = ram_word_c;
                    end else begin
                        rdata_d   = OPEN_BUS;
                        err_unm_d = 1'b1;
                    end
                end else if (hit_ram_c) begin
                    ram_we_c = 1'b1;
                end else if (hit_rom_c) begin
                    err_rom_d = 1'b1;
                end else begin
                    err_unm_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_unm_q <= 1'b0;
            err_rom_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_unm_q <= err_unm_d;
            err_rom_q <= err_rom_d;
            busy_q    <= busy_d;
        end
    end

    // Storage is not reset; a ROM read racing a load on the same edge sees the old word.
    always_ff @(posedge clk) begin
        if (load_en) begin
            rom_mem[load_address] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we_c && !rst) begin
            ram_mem[ram_idx_c] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Directed bench for bus_mem_ctrl: table of single transactions plus hand sequences
// for reset abort, load/read collision and back-to-back held requests.
module tb_bus_mem_ctrl;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 8;
    localparam int unsigned RD_W = 1;
    localparam int unsigned WR_W = 0;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_read;
    logic          cpu_write;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;
    logic          cpu_wait;
    logic          load_en;
    logic [7:0]    load_address;
    logic [DW-1:0] load_data;
    logic          err_unmapped;
    logic          err_rom_write;
    logic          busy;

    always #5 clk = ~clk;

    bus_mem_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ROM_DEPTH  (256),
        .RAM_BASE   (16'hC000),
        .RAM_DEPTH  (256),
        .READ_WAIT  (RD_W),
        .WRITE_WAIT (WR_W),
        .OPEN_BUS   (8'hFF)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_address   (cpu_address),
        .cpu_wdata     (cpu_wdata),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_rdata     (cpu_rdata),
        .cpu_done      (cpu_done),
        .cpu_wait      (cpu_wait),
        .load_en       (load_en),
        .load_address  (load_address),
        .load_data     (load_data),
        .err_unmapped  (err_unmapped),
        .err_rom_write (err_rom_write),
        .busy          (busy)
    );

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        logic          exp_unm;
        logic          exp_romw;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One transaction; latency counts rising edges from assertion until cpu_done is seen.
    task automatic do_txn(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output logic [DW-1:0] rdata,
                          output int lat, output logic unm, output logic romw,
                          output logic wait_ok);
        @(negedge clk);
        cpu_read    = rd;
        cpu_write   = wr;
        cpu_address = a;
        cpu_wdata   = wd;
        lat         = 0;
        wait_ok     = 1'b1;
        rdata       = '0;
        unm         = 1'b0;
        romw        = 1'b0;
        while (lat < 50) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (cpu_done) begin
                rdata = cpu_rdata;
                unm   = err_unmapped;
                romw  = err_rom_write;
                if (cpu_wait) wait_ok = 1'b0;
                break;
            end else if (!cpu_wait) begin
                wait_ok = 1'b0;
            end
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rom_init [6];
        logic [DW-1:0] got_rdata;
        int            got_lat;
        logic          got_unm;
        logic          got_romw;
        logic          got_wait_ok;
        int            period;

        rom_init = '{8'h3E, 8'h55, 8'h3C, 8'hC3, 8'hBB, 8'hAA};

        vecs.push_back('{1'b1, 1'b0, 16'h0000, 8'h00, 8'h3E, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0001, 8'h00, 8'h55, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0002, 8'h00, 8'h3C, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0003, 8'h00, 8'hC3, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0004, 8'h00, 8'hBB, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0005, 8'h00, 8'hAA, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0006, 8'h00, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 16'hC010, 8'h5A, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'hC010, 8'h00, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 16'h0003, 8'h99, 8'hFF, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 16'h0003, 8'h00, 8'hC3, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 16'h8000, 8'h12, 8'hC3, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'hBFFF, 8'h00, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 16'hC0FF, 8'hA5, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'hC0FF, 8'h00, 8'hA5, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'hC100, 8'h00, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h00FF, 8'h00, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0100, 8'h00, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 16'hC020, 8'h44, 8'hFF, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 16'hC020, 8'h77, 8'h44, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'hC020, 8'h00, 8'h44, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 16'hC030, 8'h22, 8'h44, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 16'h0004, 8'h00, 8'hBB, 1'b0, 1'b0});

        rst          = 1'b1;
        cpu_address  = '0;
        cpu_wdata    = '0;
        cpu_read     = 1'b0;
        cpu_write    = 1'b0;
        load_en      = 1'b0;
        load_address = '0;
        load_data    = '0;

        repeat (2) @(negedge clk);
        check("reset rdata", 32'(cpu_rdata), 32'h0);
        check("reset done", 32'(cpu_done), 32'h0);
        check("reset err_unmapped", 32'(err_unmapped), 32'h0);
        check("reset err_rom_write", 32'(err_rom_write), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset wait", 32'(cpu_wait), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            load_en      = 1'b1;
            load_address = 8'(i);
            load_data    = (i < 6) ? rom_init[i] : 8'h00;
        end
        @(negedge clk);
        load_en = 1'b0;

        foreach (vecs[i]) begin
            do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   got_rdata, got_lat, got_unm, got_romw, got_wait_ok);
            check($sformatf("v%0d@%h rdata", i, vecs[i].addr), 32'(got_rdata), 32'(vecs[i].exp_rdata));
            check($sformatf("v%0d@%h latency", i, vecs[i].addr), 32'(got_lat),
                  vecs[i].rd ? 32'(RD_W + 2) : 32'(WR_W + 2));
            check($sformatf("v%0d@%h err_unmapped", i, vecs[i].addr), 32'(got_unm), 32'(vecs[i].exp_unm));
            check($sformatf("v%0d@%h err_rom_write", i, vecs[i].addr), 32'(got_romw), 32'(vecs[i].exp_romw));
            check($sformatf("v%0d@%h cpu_wait", i, vecs[i].addr), 32'(got_wait_ok), 32'h1);
        end

        // Reset lands after the write to C030 was accepted but before it commits.
        @(negedge clk);
        cpu_write   = 1'b1;
        cpu_address = 16'hC030;
        cpu_wdata   = 8'h11;
        @(posedge clk);
        #1;
        check("abort busy before reset", 32'(busy), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("abort rdata", 32'(cpu_rdata), 32'h0);
        check("abort done", 32'(cpu_done), 32'h0);
        check("abort busy", 32'(busy), 32'h0);
        check("abort err_unmapped", 32'(err_unmapped), 32'h0);
        check("abort err_rom_write", 32'(err_rom_write), 32'h0);
        @(negedge clk);
        cpu_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_txn(1'b1, 1'b0, 16'hC030, 8'h00, got_rdata, got_lat, got_unm, got_romw, got_wait_ok);
        check("post-abort C030 rdata", 32'(got_rdata), 32'h22);
        check("post-abort latency", 32'(got_lat), 32'(RD_W + 2));

        // Load to ROM[5] on the same edge as the ACCESS read of address 5.
        @(negedge clk);
        cpu_read    = 1'b1;
        cpu_address = 16'h0005;
        repeat (RD_W + 1) @(negedge clk);
        load_en      = 1'b1;
        load_address = 8'h05;
        load_data    = 8'h5F;
        @(negedge clk);
        load_en  = 1'b0;
        cpu_read = 1'b0;
        check("collision done", 32'(cpu_done), 32'h1);
        check("collision old word", 32'(cpu_rdata), 32'hAA);
        do_txn(1'b1, 1'b0, 16'h0005, 8'h00, got_rdata, got_lat, got_unm, got_romw, got_wait_ok);
        check("collision new word", 32'(got_rdata), 32'h5F);

        // Held read request: one transaction every RD_W+3 cycles, single idle cycle between.
        period = RD_W + 3;
        @(negedge clk);
        @(negedge clk);
        cpu_read    = 1'b1;
        cpu_address = 16'h0001;
        for (int n = 1; n <= 5 * period; n++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("held n%0d done", n), 32'(cpu_done), 32'((n % period) == (period - 1)));
            check($sformatf("held n%0d busy", n), 32'(busy), 32'((n % period) != 0));
            if ((n % period) == (period - 1)) begin
                check($sformatf("held n%0d rdata", n), 32'(cpu_rdata), 32'h55);
            end
        end
        cpu_read = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
